// File: rtl/pwm_servo_scheduler_pkg.sv
// pwm_pkg: state type and default sizing shared by the servo PWM scheduler.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } pwm_state_e;

    localparam int DEF_NUM_CH    = 4;
    localparam int DEF_PERIOD    = 200000;
    localparam int DEF_CNT_W     = 18;
    localparam int DEF_MIN_PULSE = 10000;
    localparam int DEF_MAX_PULSE = 20000;

    // Channel-select width; a single channel still needs one bit.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_servo_scheduler_if.sv
// Command port of the servo PWM scheduler: valid/ready write of one
// channel width, plus a pulse flagging commands aimed at no channel.
interface pwm_servo_scheduler_if
    import pwm_pkg::*;
#(
    parameter int CH_W  = ch_w(DEF_NUM_CH),
    parameter int CNT_W = DEF_CNT_W
);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [CH_W-1:0]  cmd_ch;
    logic [CNT_W-1:0] cmd_width;
    logic             cmd_err;

    modport master (
        output cmd_valid,
        output cmd_ch,
        output cmd_width,
        input  cmd_ready,
        input  cmd_err
    );

    modport slave (
        input  cmd_valid,
        input  cmd_ch,
        input  cmd_width,
        output cmd_ready,
        output cmd_err
    );

endinterface

// File: rtl/pwm_servo_scheduler_counter.sv
// pwm_period_counter: shared period counter, wraps at PERIOD-1 only.
// clear forces zero, hold freezes the count.
module pwm_period_counter
    import pwm_pkg::*;
#(
    parameter int PERIOD = DEF_PERIOD,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             hold,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD - 1);

    assign last = (cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (!hold) begin
            cnt <= last ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pwm_servo_scheduler.sv
// Multi-channel servo PWM with shadow->active commit at period boundaries.
// Define PWM_CLAMP_EN to clamp nonzero widths to [MIN_PULSE, MAX_PULSE].
module pwm_servo_scheduler
    import pwm_pkg::*;
#(
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int PERIOD    = DEF_PERIOD,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int MIN_PULSE = DEF_MIN_PULSE,
    parameter int MAX_PULSE = DEF_MAX_PULSE
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    pwm_servo_scheduler_if.slave   cmd,
    output logic                   period_start,
    output logic [NUM_CH-1:0]      pwm_out
);

`ifdef PWM_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] LO = CNT_W'(MIN_PULSE);
    localparam logic [CNT_W-1:0] HI = CNT_W'(MAX_PULSE);

    pwm_state_e       state_q;
    pwm_state_e       state_d;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             commit;
    logic             accept;
    logic             bad_ch;
    logic [CNT_W-1:0] wdata;
    logic [CNT_W-1:0] shadow [NUM_CH];
    logic [CNT_W-1:0] active [NUM_CH];

    pwm_period_counter #(
        .PERIOD (PERIOD),
        .CNT_W  (CNT_W)
    ) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_q == IDLE && enable),
        .hold   (state_q == IDLE && !enable),
        .cnt    (cnt),
        .last   (last)
    );

    // Blocking the commit cycle keeps shadow writes from racing active.
    assign cmd.cmd_ready = !reset && !(state_q == RUN && last);
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign bad_ch        = int'(cmd.cmd_ch) >= NUM_CH;
    assign period_start  = (state_q == RUN) && (cnt == '0);

    always_comb begin
        wdata = cmd.cmd_width;
        if (CLAMP_EN && wdata != '0) begin
            if (wdata < LO) begin
                wdata = LO;
            end else if (wdata > HI) begin
                wdata = HI;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // STOP finishes the period without committing; RUN commits at wrap.
    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = RUN;
                    commit  = 1'b1;
                end
            end
            RUN: begin
                commit = last;
                if (!enable) begin
                    state_d = last ? IDLE : STOP;
                end
            end
            STOP: begin
                if (enable) begin
                    state_d = RUN;
                end else if (last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd.cmd_err <= 1'b0;
            pwm_out     <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            cmd.cmd_err <= accept && bad_ch;
            for (int i = 0; i < NUM_CH; i++) begin
                if (accept && !bad_ch && int'(cmd.cmd_ch) == i) begin
                    shadow[i] <= wdata;
                end
                if (commit) begin
                    active[i] <= shadow[i];
                end
                pwm_out[i] <= (state_q != IDLE) && (cnt < active[i]);
            end
        end
    end

endmodule

// File: tb/tb_pwm_servo_scheduler.sv
// Bench for pwm_servo_scheduler: per-period high-time model with
// directed and randomized width commands.
module tb_pwm_servo_scheduler;

    localparam int NCH  = 4;
    localparam int PER  = 100;
    localparam int CW   = 8;
    localparam int CHW  = 3;
    localparam int MINP = 5;
    localparam int MAXP = 20;

    logic           clk = 1'b0;
    logic           reset;
    logic           enable;
    logic           period_start;
    logic [NCH-1:0] pwm_out;

    int npass = 0;
    int ntot  = 0;
    int shadow [NCH];
    int active [NCH];

    always #5 clk = ~clk;

    pwm_servo_scheduler_if #(.CH_W(CHW), .CNT_W(CW)) bus ();

    pwm_servo_scheduler #(
        .NUM_CH    (NCH),
        .PERIOD    (PER),
        .CNT_W     (CW),
        .MIN_PULSE (MINP),
        .MAX_PULSE (MAXP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .cmd          (bus.slave),
        .period_start (period_start),
        .pwm_out      (pwm_out)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    endtask

    function automatic int fit(input int w);
`ifdef PWM_CLAMP_EN
        if (w == 0) return 0;
        if (w < MINP) return MINP;
        if (w > MAXP) return MAXP;
`endif
        return w;
    endfunction

    function automatic int hightime(input int w);
        return (w > PER) ? PER : w;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_cmd(input int ch, input int w);
        bus.cmd_valid = 1'b1;
        bus.cmd_ch    = CHW'(ch);
        bus.cmd_width = CW'(w);
        if (ch < NCH) shadow[ch] = fit(w);
    endtask

    task automatic load_active();
        for (int i = 0; i < NCH; i++) active[i] = shadow[i];
    endtask

    // Entered on the sample where period_start is high; leaves on the
    // sample where the next one is due.
    task automatic run_period(input int a0, input int c0, input int w0,
                              input int a1, input int c1, input int w1,
                              input int off_at, input int on_at);
        int hi [NCH];
        bit lowseen [NCH];
        bit gap [NCH];
        int rdy_bad = 0;
        int err_bad = 0;
        int ps_bad  = 0;
        logic exp_rdy;
        logic exp_err;
        for (int i = 0; i < NCH; i++) begin
            hi[i] = 0;
            lowseen[i] = 1'b0;
            gap[i] = 1'b0;
        end
        for (int k = 1; k <= PER; k++) begin
            tick();
            for (int i = 0; i < NCH; i++) begin
                if (pwm_out[i] === 1'b1) begin
                    hi[i]++;
                    if (lowseen[i]) gap[i] = 1'b1;
                end else begin
                    lowseen[i] = 1'b1;
                end
            end
            exp_rdy = !(k == PER - 1 && enable);
            exp_err = (k == a0 + 1 && c0 >= NCH) ||
                      (k == a1 + 1 && c1 >= NCH);
            if (bus.cmd_ready !== exp_rdy) rdy_bad++;
            if (bus.cmd_err !== exp_err) err_bad++;
            if (k < PER && period_start !== 1'b0) ps_bad++;
            if (k == PER) chk("period_start_wrap", period_start, enable);
            bus.cmd_valid = 1'b0;
            if (k == a0) drive_cmd(c0, w0);
            if (k == a1) drive_cmd(c1, w1);
            if (k == off_at) enable = 1'b0;
            if (k == on_at) enable = 1'b1;
        end
        for (int i = 0; i < NCH; i++) begin
            chk($sformatf("high_ch%0d", i), hi[i], hightime(active[i]));
            chk($sformatf("contig_ch%0d", i), gap[i], 0);
        end
        chk("ready_pattern", rdy_bad, 0);
        chk("err_pattern", err_bad, 0);
        chk("ps_midperiod", ps_bad, 0);
        load_active();
    endtask

    initial begin
        int idle_bad;
        reset         = 1'b1;
        enable        = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_ch    = '0;
        bus.cmd_width = '0;
        for (int i = 0; i < NCH; i++) begin
            shadow[i] = 0;
            active[i] = 0;
        end
        repeat (3) tick();
        chk("rst_pwm", pwm_out, 0);
        chk("rst_ready", bus.cmd_ready, 0);
        chk("rst_ps", period_start, 0);
        chk("rst_err", bus.cmd_err, 0);

        reset = 1'b0;
        tick();
        chk("idle_ready", bus.cmd_ready, 1);
        chk("idle_pwm", pwm_out, 0);

        // Preload in IDLE, then start.
        drive_cmd(0, 10);
        tick();
        bus.cmd_valid = 1'b0;
        chk("idle_err", bus.cmd_err, 0);
        chk("idle_ps", period_start, 0);
        enable = 1'b1;
        load_active();
        tick();
        chk("start_ps", period_start, 1);
        chk("start_pwm", pwm_out, 0);
        run_period(0, 0, 0, 0, 0, 0, 0, 0);
        run_period(0, 0, 0, 0, 0, 0, 0, 0);

        // Mid-period write only lands next period.
        run_period(30, 1, 15, 0, 0, 0, 0, 0);
        run_period(0, 0, 0, 0, 0, 0, 0, 0);

        // Clamp bounds, last write wins, over-period width.
        run_period(20, 2, 2, 21, 2, 50, 0, 0);
        run_period(10, 2, 150, 0, 0, 0, 0, 0);
        run_period(0, 0, 0, 0, 0, 0, 0, 0);

        // Out-of-range channel is dropped with an error pulse.
        run_period(12, 5, 77, 0, 0, 0, 0, 0);
        run_period(0, 0, 0, 0, 0, 0, 0, 0);

        repeat (6) begin
            run_period($urandom_range(1, 60), $urandom_range(0, 5),
                       $urandom_range(0, 150), $urandom_range(61, 97),
                       $urandom_range(0, 5), $urandom_range(0, 150),
                       0, 0);
        end

        // Stop finishes the period, then idles.
        run_period(0, 0, 0, 0, 0, 0, 40, 0);
        idle_bad = 0;
        repeat (10) begin
            tick();
            if (pwm_out !== '0 || period_start !== 1'b0) idle_bad++;
        end
        chk("stopped_idle", idle_bad, 0);
        enable = 1'b1;
        load_active();
        tick();
        chk("restart_ps", period_start, 1);
        run_period(0, 0, 0, 0, 0, 0, 40, 60);
        run_period(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset mid-pulse clears everything.
        run_period(5, 0, 10, 0, 0, 0, 0, 0);
        repeat (8) tick();
        chk("pre_reset_pwm0", pwm_out[0], 7 < hightime(active[0]));
        reset = 1'b1;
        tick();
        chk("reset_pwm", pwm_out, 0);
        chk("reset_ready", bus.cmd_ready, 0);
        reset = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            shadow[i] = 0;
            active[i] = 0;
        end
        tick();
        chk("post_reset_ps", period_start, 1);
        run_period(0, 0, 0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
